// File: rtl/led_seg_sequencer.sv
// led_seg_sequencer: LED / 7-segment chaser.
// A prescaler produces a step tick; a position register walks one active-low
// lit element in rotate-up, rotate-down, bounce or hold mode. A free-running
// scan counter rotates the one-cold anode select.
// Optional build macro LED_SEQ_PWM_EN adds a bright[3:0] input and a 4-bit
// PWM counter that blanks Led/seg/an when pwm_cnt >= bright.
module led_seg_sequencer #(
    parameter int  LED_W      = 8,
    parameter int  DIV_MAX    = 4194304,
    parameter int  NUM_DIGITS = 4,
    parameter int  SCAN_DIV   = 65536,
    localparam int POS_W      = $clog2(LED_W)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  step_i,
`ifdef LED_SEQ_PWM_EN
    input  logic [3:0]            bright,
`endif
    output logic [LED_W-1:0]      Led,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic [POS_W-1:0]      pos,
    output logic                  tick
);

    localparam int CNT_W = $clog2(DIV_MAX);

    localparam logic [1:0] M_UP     = 2'b00;
    localparam logic [1:0] M_DOWN   = 2'b01;
    localparam logic [1:0] M_BOUNCE = 2'b10;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_MAX - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(LED_W - 1);
    localparam logic [POS_W-1:0] POS_PEN  = POS_W'(LED_W - 2);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    // ------------------------------------------------------------------
    // Prescaler and step tick
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             advance;

    // Next prescaler count; a manual step restarts the period and swallows
    // a tick landing in the same cycle so only one advance happens.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (step_i) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == DIV_LAST) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign advance = tick_d | step_i;

    // Prescaler count and registered tick pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

    // ------------------------------------------------------------------
    // Position / direction
    // ------------------------------------------------------------------
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;

    // Next position for the current mode; registered on the same edge as the
    // advance so the decoded outputs show the new position without delay.
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (advance) begin
            case (mode)
                M_UP: begin
                    dir_d = DIR_UP;
                    pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_ONE;
                end
                M_DOWN: begin
                    dir_d = DIR_DOWN;
                    pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_ONE;
                end
                M_BOUNCE: begin
                    // Turn around without dwelling on the end element.
                    if (dir_q == DIR_UP) begin
                        if (pos_q == POS_LAST) begin
                            dir_d = DIR_DOWN;
                            pos_d = POS_PEN;
                        end else begin
                            pos_d = pos_q + POS_ONE;
                        end
                    end else begin
                        if (pos_q == '0) begin
                            dir_d = DIR_UP;
                            pos_d = POS_ONE;
                        end else begin
                            pos_d = pos_q - POS_ONE;
                        end
                    end
                end
                default: begin
                    // hold: position and direction unchanged
                end
            endcase
        end
    end

    // Position and direction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
            dir_q <= DIR_UP;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign pos = pos_q;

    // ------------------------------------------------------------------
    // LED and segment decode (active-low, one-cold)
    // ------------------------------------------------------------------
    logic [LED_W-1:0] led_pat;
    logic [7:0]       seg_pat;
    logic [2:0]       pos3;

    generate
        if (POS_W >= 3) begin : g_pos3_slice
            assign pos3 = pos_q[2:0];
        end else begin : g_pos3_ext
            assign pos3 = {{(3 - POS_W){1'b0}}, pos_q};
        end
    endgenerate

    // One-cold decode of the registered position onto LEDs and segments.
    always_comb begin
        led_pat          = '1;
        led_pat[pos_q]   = 1'b0;
        seg_pat          = 8'hFF;
        seg_pat[pos3]    = 1'b0;
    end

    // ------------------------------------------------------------------
    // Anode scan
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] an_pat;

    generate
        if (NUM_DIGITS == 1) begin : g_single_digit
            assign an_pat = 1'b0;
        end else begin : g_scan
            localparam int SCAN_W = $clog2(SCAN_DIV);
            localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

            logic [SCAN_W-1:0]     scan_q, scan_d;
            logic [NUM_DIGITS-1:0] an_q, an_d;

            // Free-running scan divider; rotate the one-cold anode on wrap.
            always_comb begin
                scan_d = scan_q + SCAN_W'(1);
                an_d   = an_q;
                if (scan_q == SCAN_LAST) begin
                    scan_d = '0;
                    an_d   = {an_q[NUM_DIGITS-2:0], an_q[NUM_DIGITS-1]};
                end
            end

            // Scan counter and anode select registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    scan_q <= '0;
                    an_q   <= {{(NUM_DIGITS - 1){1'b1}}, 1'b0};
                end else begin
                    scan_q <= scan_d;
                    an_q   <= an_d;
                end
            end

            assign an_pat = an_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output stage (optional PWM dimming)
    // ------------------------------------------------------------------
`ifdef LED_SEQ_PWM_EN
    logic [3:0] pwm_q;
    logic       dark;

    // Free-running PWM phase counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= 4'd0;
        end else begin
            pwm_q <= pwm_q + 4'd1;
        end
    end

    assign dark = (pwm_q >= bright);

    assign Led = dark ? '1    : led_pat;
    assign seg = dark ? 8'hFF : seg_pat;
    assign an  = dark ? '1    : an_pat;
`else
    assign Led = led_pat;
    assign seg = seg_pat;
    assign an  = an_pat;
`endif

endmodule

// File: tb/tb_led_seg_sequencer.sv
// Directed bench for led_seg_sequencer with LED_W=8, DIV_MAX=4,
// NUM_DIGITS=4, SCAN_DIV=3. Outputs sampled 1 time unit after posedge.
module tb_led_seg_sequencer;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       step_i;
    logic [3:0] bright;
    logic [7:0] Led;
    logic [7:0] seg;
    logic [3:0] an;
    logic [2:0] pos;
    logic       tick;

    int checks = 0;
    int errors = 0;

    led_seg_sequencer #(
        .LED_W(8), .DIV_MAX(4), .NUM_DIGITS(4), .SCAN_DIV(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .step_i(step_i),
`ifdef LED_SEQ_PWM_EN
        .bright(bright),
`endif
        .Led(Led), .seg(seg), .an(an), .pos(pos), .tick(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected visibility of the display outputs.
`ifdef LED_SEQ_PWM_EN
    logic [3:0] m_pwm;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_pwm <= 4'd0;
        else        m_pwm <= m_pwm + 4'd1;
    end
    wire lit = (m_pwm < bright);
`else
    wire lit = 1'b1;
`endif

    function automatic logic [7:0] el8(input logic [7:0] v);
        return lit ? v : 8'hFF;
    endfunction

    function automatic logic [3:0] el4(input logic [3:0] v);
        return lit ? v : 4'hF;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; step_i = 1'b0; bright = 4'd15;
        #12;
        checks++; if (Led !== el8(8'hFE)) begin errors++; $display("FAIL reset_led got %h exp %h", Led, el8(8'hFE)); end
        checks++; if (seg !== el8(8'hFE)) begin errors++; $display("FAIL reset_seg got %h exp %h", seg, el8(8'hFE)); end
        checks++; if (an !== el4(4'hE)) begin errors++; $display("FAIL reset_an got %h exp %h", an, el4(4'hE)); end
        checks++; if (pos !== 3'd0) begin errors++; $display("FAIL reset_pos got %0d exp 0", pos); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", tick); end
        @(posedge clk); #1;
        rst_n = 1'b1; en = 1'b1;
    endtask

    task automatic test_rotate_up();
        logic [7:0] led_tbl [8] = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
        logic [2:0] pos_tbl [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        for (int t = 0; t < 8; t++) begin
            repeat (3) cyc();
            checks++; if (tick !== 1'b0) begin errors++; $display("FAIL up_notick[%0d] got %b exp 0", t, tick); end
            cyc();
            checks++; if (tick !== 1'b1) begin errors++; $display("FAIL up_tick[%0d] got %b exp 1", t, tick); end
            checks++; if (pos !== pos_tbl[t]) begin errors++; $display("FAIL up_pos[%0d] got %0d exp %0d", t, pos, pos_tbl[t]); end
            checks++; if (Led !== el8(led_tbl[t])) begin errors++; $display("FAIL up_led[%0d] got %h exp %h", t, Led, el8(led_tbl[t])); end
            checks++; if (seg !== el8(led_tbl[t])) begin errors++; $display("FAIL up_seg[%0d] got %h exp %h", t, seg, el8(led_tbl[t])); end
        end
    endtask

    task automatic test_rotate_down();
        mode = 2'b01;
        repeat (4) cyc();
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL down_tick got %b exp 1", tick); end
        checks++; if (pos !== 3'd7) begin errors++; $display("FAIL down_pos got %0d exp 7", pos); end
        checks++; if (Led !== el8(8'h7F)) begin errors++; $display("FAIL down_led got %h exp %h", Led, el8(8'h7F)); end
        checks++; if (seg !== el8(8'h7F)) begin errors++; $display("FAIL down_seg got %h exp %h", seg, el8(8'h7F)); end
    endtask

    task automatic test_bounce();
        logic [2:0] pos_tbl [16] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
                                     3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
        mode = 2'b00;
        repeat (4) cyc();
        checks++; if (pos !== 3'd0) begin errors++; $display("FAIL bounce_start got %0d exp 0", pos); end
        mode = 2'b10;
        for (int t = 0; t < 16; t++) begin
            repeat (4) cyc();
            checks++; if (pos !== pos_tbl[t]) begin errors++; $display("FAIL bounce_pos[%0d] got %0d exp %0d", t, pos, pos_tbl[t]); end
        end
        checks++; if (Led !== el8(8'hFB)) begin errors++; $display("FAIL bounce_led got %h exp %h", Led, el8(8'hFB)); end
    endtask

    task automatic test_hold();
        mode = 2'b11;
        for (int t = 0; t < 10; t++) begin
            repeat (4) cyc();
            checks++; if (tick !== 1'b1) begin errors++; $display("FAIL hold_tick[%0d] got %b exp 1", t, tick); end
            checks++; if (pos !== 3'd2) begin errors++; $display("FAIL hold_pos[%0d] got %0d exp 2", t, pos); end
        end
    endtask

    task automatic test_en_low();
        repeat (2) cyc();          // prescaler now at 2
        en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            checks++; if (tick !== 1'b0) begin errors++; $display("FAIL enlow_tick[%0d] got %b exp 0", c, tick); end
        end
        checks++; if (pos !== 3'd2) begin errors++; $display("FAIL enlow_pos got %0d exp 2", pos); end
        en = 1'b1;
        cyc();
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL enlow_resume0 got %b exp 0", tick); end
        cyc();
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL enlow_resume1 got %b exp 1", tick); end
    endtask

    task automatic test_step();
        en = 1'b0; mode = 2'b00;
        step_i = 1'b1; cyc(); step_i = 1'b0;
        checks++; if (pos !== 3'd3) begin errors++; $display("FAIL step_pos got %0d exp 3", pos); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL step_tick got %b exp 0", tick); end
        checks++; if (Led !== el8(8'hF7)) begin errors++; $display("FAIL step_led got %h exp %h", Led, el8(8'hF7)); end
        repeat (5) cyc();
        checks++; if (pos !== 3'd3) begin errors++; $display("FAIL step_idle got %0d exp 3", pos); end
        step_i = 1'b1; cyc(); step_i = 1'b0;
        checks++; if (pos !== 3'd4) begin errors++; $display("FAIL step2_pos got %0d exp 4", pos); end
    endtask

    task automatic test_back_to_back();
        en = 1'b1;
        repeat (3) cyc();          // prescaler at DIV_MAX-1
        step_i = 1'b1; cyc(); step_i = 1'b0;
        checks++; if (pos !== 3'd5) begin errors++; $display("FAIL coinc_pos got %0d exp 5", pos); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL coinc_tick got %b exp 0", tick); end
        for (int c = 0; c < 3; c++) begin
            cyc();
            checks++; if (tick !== 1'b0) begin errors++; $display("FAIL coinc_gap[%0d] got %b exp 0", c, tick); end
        end
        cyc();
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL coinc_next got %b exp 1", tick); end
        checks++; if (pos !== 3'd6) begin errors++; $display("FAIL coinc_next_pos got %0d exp 6", pos); end
    endtask

    task automatic test_async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (Led !== el8(8'hFE)) begin errors++; $display("FAIL areset_led got %h exp %h", Led, el8(8'hFE)); end
        checks++; if (seg !== el8(8'hFE)) begin errors++; $display("FAIL areset_seg got %h exp %h", seg, el8(8'hFE)); end
        checks++; if (an !== el4(4'hE)) begin errors++; $display("FAIL areset_an got %h exp %h", an, el4(4'hE)); end
        checks++; if (pos !== 3'd0) begin errors++; $display("FAIL areset_pos got %0d exp 0", pos); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL areset_tick got %b exp 0", tick); end
        en = 1'b0; mode = 2'b11;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        logic [3:0] an_tbl [12] = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hD, 4'hB,
                                    4'hB, 4'hB, 4'h7, 4'h7, 4'h7, 4'hE};
        for (int c = 0; c < 12; c++) begin
            cyc();
            checks++; if (an !== el4(an_tbl[c])) begin errors++; $display("FAIL scan_an[%0d] got %h exp %h", c, an, el4(an_tbl[c])); end
        end
    endtask

`ifdef LED_SEQ_PWM_EN
    task automatic test_pwm();
        int on_cnt;
        bright = 4'd4;
        on_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            cyc();
            if (Led !== 8'hFF) on_cnt++;
        end
        checks++; if (on_cnt != 4) begin errors++; $display("FAIL pwm_duty got %0d exp 4", on_cnt); end
        bright = 4'd0; en = 1'b1; mode = 2'b00;
        for (int c = 0; c < 16; c++) begin
            cyc();
            checks++; if (Led !== 8'hFF || seg !== 8'hFF || an !== 4'hF) begin
                errors++; $display("FAIL pwm_dark[%0d] got %h/%h/%h exp FF/FF/F", c, Led, seg, an);
            end
        end
        checks++; if (pos !== 3'd4) begin errors++; $display("FAIL pwm_pos got %0d exp 4", pos); end
    endtask
`endif

    initial begin
        test_reset();
        test_rotate_up();
        test_rotate_down();
        test_bounce();
        test_hold();
        test_en_low();
        test_step();
        test_back_to_back();
        test_async_reset();
        test_scan();
`ifdef LED_SEQ_PWM_EN
        test_pwm();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
